// File: rtl/ct_rtu_onehot_ptr_32_if.sv
// Bundle of request/status signals between the retire-queue pointer manager
// and its user. The slave side is the pointer manager itself.
interface ct_rtu_onehot_ptr_32_if;
    logic        x_flush;
    logic [1:0]  x_alloc_num;
    logic [1:0]  x_release_num;
    logic        x_alloc_gnt;
    logic [31:0] x_create_ptr0_expand;
    logic [31:0] x_create_ptr1_expand;
    logic [31:0] x_retire_ptr0_expand;
    logic [31:0] x_retire_ptr1_expand;
    logic [5:0]  x_entry_cnt;
    logic        x_empty;
    logic        x_full;
    logic        x_err;

    modport master (
        output x_flush, x_alloc_num, x_release_num,
        input  x_alloc_gnt, x_create_ptr0_expand, x_create_ptr1_expand,
               x_retire_ptr0_expand, x_retire_ptr1_expand,
               x_entry_cnt, x_empty, x_full, x_err
    );

    modport slave (
        input  x_flush, x_alloc_num, x_release_num,
        output x_alloc_gnt, x_create_ptr0_expand, x_create_ptr1_expand,
               x_retire_ptr0_expand, x_retire_ptr1_expand,
               x_entry_cnt, x_empty, x_full, x_err
    );
endinterface

// File: rtl/ct_rtu_onehot_ptr_32.sv
// One-hot create/retire pointer manager for a 32-entry circular retire queue.
// Up to two allocations and two releases per cycle; sticky protocol error flag.
module ct_rtu_onehot_ptr_32 (
    input  logic                   cpuclk,
    input  logic                   cpurst,
    ct_rtu_onehot_ptr_32_if.slave  bus
);

    logic [31:0] create_ptr_q, create_ptr_d;
    logic [31:0] retire_ptr_q, retire_ptr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [1:0]  alloc_req;
    logic [1:0]  rel_req;
    logic [5:0]  free_cnt;
    logic        alloc_gnt;
    logic        rel_ok;
    logic        proto_err;
    logic [5:0]  gnt_num;
    logic [5:0]  rel_num;

    function automatic logic [31:0] rotl(input logic [31:0] p, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd1:    r = {p[30:0], p[31]};
            2'd2:    r = {p[29:0], p[31:30]};
            default: r = p;
        endcase
        return r;
    endfunction

    // An encoding of 3 is illegal and behaves as a zero-size request.
    always_comb begin
        alloc_req = (bus.x_alloc_num   == 2'd3) ? 2'd0 : bus.x_alloc_num;
        rel_req   = (bus.x_release_num == 2'd3) ? 2'd0 : bus.x_release_num;
        free_cnt  = 6'd32 - cnt_q;
        alloc_gnt = !cpurst && !bus.x_flush && (alloc_req != 2'd0)
                    && (free_cnt >= {4'd0, alloc_req});
        rel_ok    = (rel_req != 2'd0) && ({4'd0, rel_req} <= cnt_q);
        proto_err = (bus.x_alloc_num == 2'd3) || (bus.x_release_num == 2'd3)
                    || ((rel_req != 2'd0) && ({4'd0, rel_req} > cnt_q));
        gnt_num   = alloc_gnt ? {4'd0, alloc_req} : 6'd0;
        rel_num   = rel_ok    ? {4'd0, rel_req}   : 6'd0;
    end

    always_comb begin
        create_ptr_d = create_ptr_q;
        retire_ptr_d = retire_ptr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        if (bus.x_flush) begin
            create_ptr_d = 32'h0000_0001;
            retire_ptr_d = 32'h0000_0001;
            cnt_d        = 6'd0;
        end else begin
            if (alloc_gnt) create_ptr_d = rotl(create_ptr_q, alloc_req);
            if (rel_ok)    retire_ptr_d = rotl(retire_ptr_q, rel_req);
            cnt_d = cnt_q + gnt_num - rel_num;
            err_d = err_q | proto_err;
        end
    end

    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            create_ptr_q <= 32'h0000_0001;
            retire_ptr_q <= 32'h0000_0001;
            cnt_q        <= 6'd0;
            err_q        <= 1'b0;
        end else begin
            create_ptr_q <= create_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.x_alloc_gnt          = alloc_gnt;
    assign bus.x_create_ptr0_expand = create_ptr_q;
    assign bus.x_create_ptr1_expand = rotl(create_ptr_q, 2'd1);
    assign bus.x_retire_ptr0_expand = retire_ptr_q;
    assign bus.x_retire_ptr1_expand = rotl(retire_ptr_q, 2'd1);
    assign bus.x_entry_cnt          = cnt_q;
    assign bus.x_empty              = (cnt_q == 6'd0);
    assign bus.x_full               = (cnt_q == 6'd32);
    assign bus.x_err                = err_q;

endmodule

// File: tb/tb_ct_rtu_onehot_ptr_32.sv
// Self-checking bench for ct_rtu_onehot_ptr_32: hand-written vector table,
// directed corner sequences and randomized traffic against an index-based model.
module tb_ct_rtu_onehot_ptr_32;

    logic cpuclk = 1'b0;
    logic cpurst = 1'b1;
    ct_rtu_onehot_ptr_32_if bus ();

    ct_rtu_onehot_ptr_32 dut (.cpuclk(cpuclk), .cpurst(cpurst), .bus(bus));

    always #5 cpuclk = ~cpuclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue described by head/tail indices and an occupancy.
    int m_c   = 0;
    int m_r   = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    typedef struct {
        bit       fl;
        bit [1:0] an;
        bit [1:0] rn;
        bit       gnt;
        int       cnt;
        int       cidx;
        int       ridx;
        bit       err;
    } vec_t;

    function automatic logic [31:0] oh(input int i);
        return 32'h1 << (i % 32);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_gnt(input bit rst, input bit fl, input int an);
        return !rst && !fl && (an == 1 || an == 2) && (32 - m_cnt >= an);
    endfunction

    task automatic model_clock(input bit rst, input bit fl, input int an, input int rn);
        bit g;
        bit rel_ok;
        if (rst) begin
            m_c = 0; m_r = 0; m_cnt = 0; m_err = 1'b0;
        end else if (fl) begin
            m_c = 0; m_r = 0; m_cnt = 0;
        end else begin
            g      = model_gnt(1'b0, 1'b0, an);
            rel_ok = (rn == 1 || rn == 2) && rn <= m_cnt;
            if (an == 3 || rn == 3 || ((rn == 1 || rn == 2) && rn > m_cnt)) m_err = 1'b1;
            if (rel_ok) begin
                m_r   = (m_r + rn) % 32;
                m_cnt = m_cnt - rn;
            end
            if (g) begin
                m_c   = (m_c + an) % 32;
                m_cnt = m_cnt + an;
            end
        end
    endtask

    task automatic check_all();
        check("create_ptr0", bus.x_create_ptr0_expand, oh(m_c));
        check("create_ptr1", bus.x_create_ptr1_expand, oh(m_c + 1));
        check("retire_ptr0", bus.x_retire_ptr0_expand, oh(m_r));
        check("retire_ptr1", bus.x_retire_ptr1_expand, oh(m_r + 1));
        check("entry_cnt",   {26'd0, bus.x_entry_cnt}, m_cnt);
        check("empty",       {31'd0, bus.x_empty},     (m_cnt == 0));
        check("full",        {31'd0, bus.x_full},      (m_cnt == 32));
        check("err",         {31'd0, bus.x_err},       m_err);
    endtask

    // Called just after a falling edge: drive, check grant, clock, check state.
    task automatic step(input bit rst, input bit fl, input int an, input int rn);
        cpurst            = rst;
        bus.x_flush       = fl;
        bus.x_alloc_num   = 2'(an);
        bus.x_release_num = 2'(rn);
        #1;
        check("alloc_gnt", {31'd0, bus.x_alloc_gnt}, model_gnt(rst, fl, an));
        @(posedge cpuclk);
        model_clock(rst, fl, an, rn);
        @(negedge cpuclk);
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1, 0);
        cpurst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    vec_t vecs[8];

    initial begin
        bus.x_flush       = 1'b0;
        bus.x_alloc_num   = 2'd0;
        bus.x_release_num = 2'd0;

        vecs[0] = '{fl:0, an:1, rn:0, gnt:1, cnt:1, cidx:1, ridx:0, err:0};
        vecs[1] = '{fl:0, an:2, rn:0, gnt:1, cnt:3, cidx:3, ridx:0, err:0};
        vecs[2] = '{fl:0, an:2, rn:1, gnt:1, cnt:4, cidx:5, ridx:1, err:0};
        vecs[3] = '{fl:0, an:0, rn:2, gnt:0, cnt:2, cidx:5, ridx:3, err:0};
        vecs[4] = '{fl:0, an:0, rn:2, gnt:0, cnt:0, cidx:5, ridx:5, err:0};
        vecs[5] = '{fl:0, an:1, rn:1, gnt:1, cnt:1, cidx:6, ridx:5, err:1};
        vecs[6] = '{fl:0, an:3, rn:0, gnt:0, cnt:1, cidx:6, ridx:5, err:1};
        vecs[7] = '{fl:1, an:1, rn:1, gnt:0, cnt:0, cidx:0, ridx:0, err:1};

        @(negedge cpuclk);
        do_reset();
        check("rst_create0", bus.x_create_ptr0_expand, 32'h1);
        check("rst_create1", bus.x_create_ptr1_expand, 32'h2);
        check("rst_retire1", bus.x_retire_ptr1_expand, 32'h2);
        check("rst_empty",   {31'd0, bus.x_empty}, 32'd1);

        foreach (vecs[i]) begin
            bus.x_flush       = vecs[i].fl;
            bus.x_alloc_num   = vecs[i].an;
            bus.x_release_num = vecs[i].rn;
            #1;
            check($sformatf("vec%0d_gnt", i), {31'd0, bus.x_alloc_gnt}, vecs[i].gnt);
            @(posedge cpuclk);
            model_clock(1'b0, vecs[i].fl, vecs[i].an, vecs[i].rn);
            @(negedge cpuclk);
            check($sformatf("vec%0d_cnt", i),    {26'd0, bus.x_entry_cnt}, vecs[i].cnt);
            check($sformatf("vec%0d_create", i), bus.x_create_ptr0_expand, oh(vecs[i].cidx));
            check($sformatf("vec%0d_retire", i), bus.x_retire_ptr0_expand, oh(vecs[i].ridx));
            check($sformatf("vec%0d_err", i),    {31'd0, bus.x_err}, vecs[i].err);
        end

        // Fill one at a time, wrap to full, then a refused 33rd request.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1, 0);
        check("fill_full",    {31'd0, bus.x_full}, 32'd1);
        check("fill_cnt",     {26'd0, bus.x_entry_cnt}, 32'd32);
        check("fill_wrap",    bus.x_create_ptr0_expand, 32'h1);
        step(1'b0, 1'b0, 1, 0);

        // All-or-nothing grant at cnt=31.
        do_reset();
        for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 1, 0);
        step(1'b0, 1'b0, 2, 0);
        check("refuse2_cnt", {26'd0, bus.x_entry_cnt}, 32'd31);
        step(1'b0, 1'b0, 1, 0);
        check("last1_cnt",   {26'd0, bus.x_entry_cnt}, 32'd32);

        // Pairs in, pairs out, retire pointer wraps home.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 0, 2);
        check("drain_retire", bus.x_retire_ptr0_expand, 32'h1);
        check("drain_empty",  {31'd0, bus.x_empty}, 32'd1);
        check("drain_err",    {31'd0, bus.x_err}, 32'd0);

        // Simultaneous alloc 2 / release 2 at cnt=10.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2, 0);
        step(1'b0, 1'b0, 2, 2);
        check("swap_cnt",     {26'd0, bus.x_entry_cnt}, 32'd10);
        check("swap_create",  bus.x_create_ptr0_expand, 32'h1 << 12);
        check("swap_create1", bus.x_create_ptr1_expand, 32'h1 << 13);
        check("swap_retire",  bus.x_retire_ptr0_expand, 32'h1 << 2);

        // Over-release sets sticky err; flush keeps it; reset clears it.
        do_reset();
        step(1'b0, 1'b0, 1, 0);
        step(1'b0, 1'b0, 0, 2);
        check("overrel_cnt", {26'd0, bus.x_entry_cnt}, 32'd1);
        check("overrel_err", {31'd0, bus.x_err}, 32'd1);
        step(1'b0, 1'b1, 0, 0);
        check("flush_err",   {31'd0, bus.x_err}, 32'd1);
        check("flush_ptr",   bus.x_create_ptr0_expand, 32'h1);
        do_reset();
        check("rst_err",     {31'd0, bus.x_err}, 32'd0);

        // Flush beats a same-cycle allocation.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1, 0);
        step(1'b0, 1'b1, 1, 0);
        check("flush_cnt",    {26'd0, bus.x_entry_cnt}, 32'd0);
        check("flush_retire", bus.x_retire_ptr0_expand, 32'h1);

        // Randomized traffic in phases biased toward filling and draining.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, a, b, an, rn;
            bit rst, fl;
            r   = $urandom_range(0, 199);
            rst = (r == 0);
            fl  = (r >= 1 && r <= 3);
            a   = $urandom_range(0, 19);
            b   = $urandom_range(0, 19);
            if ((i / 300) % 2 == 0) begin
                an = (a < 4) ? 0 : (a < 11) ? 1 : (a < 19) ? 2 : 3;
                rn = (b < 12) ? 0 : (b < 16) ? 1 : (b < 19) ? 2 : 3;
            end else begin
                an = (a < 12) ? 0 : (a < 16) ? 1 : (a < 19) ? 2 : 3;
                rn = (b < 4) ? 0 : (b < 11) ? 1 : (b < 19) ? 2 : 3;
            end
            step(rst, fl, an, rn);
        end
        cpurst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
